alu_arbiter: RTL and testbench

Shares the single `alu` instance between two requesters (e.g. decode/issue and a multi-cycle helper unit). Accepts one operation at a time over a valid/ready handshake, drives the ALU operand and mode inputs, waits the ALU latency, captures `rd`, and returns the result to the owning requester. Selection is round-robin. The block has no pipelining: at most one operation is in flight.

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one ALU, with one operation in flight
// at a time. Requests are granted round-robin, and each result goes back to the
// requester that issued it.
module alu_arbiter #(
    parameter int ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [3:0]  req0_mode,
    input  logic [3:0]  req1_mode,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [31:0] req1_rs2,
    output logic        resp0_valid,
    output logic        resp1_valid,
    input  logic        resp0_ready,
    input  logic        resp1_ready,
    output logic [31:0] resp_rd,
    output logic [3:0]  alu_mode,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    input  logic [31:0] alu_rd,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

    state_t      state_reg;
    state_t      state_next;
    logic        owner_reg;
    logic        rr_ptr_reg;
    logic [3:0]  lat_cnt_reg;
    logic [3:0]  alu_mode_reg;
    logic [31:0] alu_rs1_reg;
    logic [31:0] alu_rs2_reg;
    logic [31:0] resp_rd_reg;

    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        resp_done;

    // Round-robin grant: a lone requester always wins, and a tie goes to rr_ptr
    always_comb begin
        grant0 = req0_valid && (!req1_valid || !rr_ptr_reg);
        grant1 = req1_valid && (!req0_valid ||  rr_ptr_reg);
    end

    assign accept    = (state_reg == IDLE) && (req0_valid || req1_valid);
    assign resp_done = (state_reg == RESP) && (owner_reg ? resp1_ready : resp0_ready);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)               state_next = EXEC;
            EXEC:    if (lat_cnt_reg == 4'd1)  state_next = RESP;
            RESP:    if (resp_done)            state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // Operand latch on accept, latency countdown, result capture and pointer update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_reg    <= 1'b0;
            rr_ptr_reg   <= 1'b0;
            lat_cnt_reg  <= 4'd0;
            alu_mode_reg <= 4'd0;
            alu_rs1_reg  <= 32'd0;
            alu_rs2_reg  <= 32'd0;
            resp_rd_reg  <= 32'd0;
        end else begin
            if (accept) begin
                owner_reg    <= grant1;
                lat_cnt_reg  <= LAT_INIT;
                alu_mode_reg <= grant1 ? req1_mode : req0_mode;
                alu_rs1_reg  <= grant1 ? req1_rs1  : req0_rs1;
                alu_rs2_reg  <= grant1 ? req1_rs2  : req0_rs2;
            end
            if (state_reg == EXEC) begin
                lat_cnt_reg <= lat_cnt_reg - 4'd1;
                if (lat_cnt_reg == 4'd1) begin
                    resp_rd_reg <= alu_rd;
                end
            end
            // The requester just served loses the next tie
            if (resp_done) begin
                rr_ptr_reg <= ~owner_reg;
            end
        end
    end

    // Handshake and status outputs decoded from state and owner
    always_comb begin
        req0_ready  = (state_reg == IDLE) && grant0;
        req1_ready  = (state_reg == IDLE) && grant1;
        resp0_valid = (state_reg == RESP) && !owner_reg;
        resp1_valid = (state_reg == RESP) &&  owner_reg;
        busy        = (state_reg != IDLE);
    end

    assign alu_mode = alu_mode_reg;
    assign alu_rs1  = alu_rs1_reg;
    assign alu_rs2  = alu_rs2_reg;
    assign resp_rd  = resp_rd_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiters (ALU_LAT=1 and ALU_LAT=3) driving a behavioural
// ALU with matching latency, checked against transaction-level expectations.
module tb_alu_arbiter;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_SLL  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SRL  = 4'd6;
    localparam logic [3:0] ALU_OP_SRA  = 4'd7;
    localparam logic [3:0] ALU_OP_OR   = 4'd8;
    localparam logic [3:0] ALU_OP_AND  = 4'd9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         [2];
    logic        req0_valid  [2];
    logic        req1_valid  [2];
    logic        req0_ready  [2];
    logic        req1_ready  [2];
    logic [3:0]  req0_mode   [2];
    logic [3:0]  req1_mode   [2];
    logic [31:0] req0_rs1    [2];
    logic [31:0] req1_rs1    [2];
    logic [31:0] req0_rs2    [2];
    logic [31:0] req1_rs2    [2];
    logic        resp0_valid [2];
    logic        resp1_valid [2];
    logic        resp0_ready [2];
    logic        resp1_ready [2];
    logic [31:0] resp_rd     [2];
    logic [3:0]  alu_mode    [2];
    logic [31:0] alu_rs1     [2];
    logic [31:0] alu_rs2     [2];
    logic [31:0] alu_rd      [2];
    logic        busy        [2];

    int errors = 0;
    int checks = 0;
    int exp_rr [2];

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Reference ALU behaviour; undefined codes produce an arbitrary mix
    function automatic logic [31:0] alu_func(input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
        case (m)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_SLL:  return a << b[4:0];
            ALU_OP_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_OP_SLTU: return {31'd0, a < b};
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> b[4:0];
            ALU_OP_SRA:  return 32'($signed(a) >>> b[4:0]);
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            default:     return a ^ b ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    // Behavioural ALU: the result of stable inputs appears ALU_LAT cycles later
    logic [31:0] pipe [2][16];
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            pipe[u][0] <= alu_func(alu_mode[u], alu_rs1[u], alu_rs2[u]);
            for (int k = 1; k < 16; k++) pipe[u][k] <= pipe[u][k-1];
        end
    end
    always_comb begin
        for (int u = 0; u < 2; u++) begin
            alu_rd[u] = (lat_of(u) == 1) ? alu_func(alu_mode[u], alu_rs1[u], alu_rs2[u])
                                         : pipe[u][(lat_of(u) > 1) ? lat_of(u) - 2 : 0];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu_arbiter #(.ALU_LAT(gi == 0 ? 1 : 3)) dut (
            .clk         (clk),
            .reset       (rst[gi]),
            .req0_valid  (req0_valid[gi]),
            .req1_valid  (req1_valid[gi]),
            .req0_ready  (req0_ready[gi]),
            .req1_ready  (req1_ready[gi]),
            .req0_mode   (req0_mode[gi]),
            .req1_mode   (req1_mode[gi]),
            .req0_rs1    (req0_rs1[gi]),
            .req1_rs1    (req1_rs1[gi]),
            .req0_rs2    (req0_rs2[gi]),
            .req1_rs2    (req1_rs2[gi]),
            .resp0_valid (resp0_valid[gi]),
            .resp1_valid (resp1_valid[gi]),
            .resp0_ready (resp0_ready[gi]),
            .resp1_ready (resp1_ready[gi]),
            .resp_rd     (resp_rd[gi]),
            .alu_mode    (alu_mode[gi]),
            .alu_rs1     (alu_rs1[gi]),
            .alu_rs2     (alu_rs2[gi]),
            .alu_rd      (alu_rd[gi]),
            .busy        (busy[gi])
        );
    end

    task automatic clear_inputs(input int u);
        req0_valid[u] = 1'b0; req1_valid[u] = 1'b0;
        req0_mode[u]  = 4'd0; req1_mode[u]  = 4'd0;
        req0_rs1[u]   = 32'd0; req0_rs2[u]  = 32'd0;
        req1_rs1[u]   = 32'd0; req1_rs2[u]  = 32'd0;
        resp0_ready[u] = 1'b1; resp1_ready[u] = 1'b1;
    endtask

    task automatic set_req(input int u, input int r, input logic [3:0] m, input logic [31:0] a, input logic [31:0] b);
        if (r == 0) begin
            req0_valid[u] = 1'b1; req0_mode[u] = m; req0_rs1[u] = a; req0_rs2[u] = b;
        end else begin
            req1_valid[u] = 1'b1; req1_mode[u] = m; req1_rs1[u] = a; req1_rs2[u] = b;
        end
    endtask

    // Counts edges (including the accept edge) until a response valid shows up
    task automatic wait_resp(input int u, output int k, output int who);
        k = 0;
        who = -1;
        while (who < 0 && k < 40) begin
            @(negedge clk); #1;
            k++;
            if (resp0_valid[u]) who = 0;
            else if (resp1_valid[u]) who = 1;
        end
    endtask

    task automatic test_reset(input int u);
        @(negedge clk);
        rst[u] = 1'b0;
        clear_inputs(u);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy[u], req0_ready[u], req1_ready[u], resp0_valid[u], resp1_valid[u],
             alu_mode[u], alu_rs1[u], alu_rs2[u], resp_rd[u]} !== '0)
            begin errors++; $display("FAIL reset_outputs u%0d: busy=%b alu_mode=%h rs1=%h rs2=%h rd=%h, required all 0",
                                     u, busy[u], alu_mode[u], alu_rs1[u], alu_rs2[u], resp_rd[u]); end
        @(negedge clk);
        rst[u] = 1'b1;
        exp_rr[u] = 0;
    endtask

    task automatic test_single(input int u);
        int k, who;
        @(negedge clk);
        set_req(u, 0, ALU_OP_ADD, 32'd18, 32'd12);
        #1;
        checks++;
        if ({req0_ready[u], req1_ready[u]} !== 2'b10)
            begin errors++; $display("FAIL single_ready u%0d: got %b required 10", u, {req0_ready[u], req1_ready[u]}); end
        @(posedge clk); #1;
        req0_valid[u] = 1'b0;
        wait_resp(u, k, who);
        checks++;
        if (k !== lat_of(u) + 1)
            begin errors++; $display("FAIL single_latency u%0d: got %0d required %0d", u, k, lat_of(u) + 1); end
        checks++;
        if (who !== 0 || resp1_valid[u] !== 1'b0)
            begin errors++; $display("FAIL single_owner u%0d: got %0d (resp1=%b) required 0", u, who, resp1_valid[u]); end
        checks++;
        if (resp_rd[u] !== 32'd30)
            begin errors++; $display("FAIL single_result u%0d: got %h required %h", u, resp_rd[u], 32'd30); end
        checks++;
        if ({alu_mode[u], alu_rs1[u], alu_rs2[u]} !== {ALU_OP_ADD, 32'd18, 32'd12})
            begin errors++; $display("FAIL single_alu_in u%0d: got %h/%h/%h", u, alu_mode[u], alu_rs1[u], alu_rs2[u]); end
        @(negedge clk); #1;
        checks++;
        if ({busy[u], resp0_valid[u]} !== 2'b00)
            begin errors++; $display("FAIL single_done u%0d: busy/valid got %b required 00", u, {busy[u], resp0_valid[u]}); end
        exp_rr[u] = 1;
        $display("txn u%0d single ADD 18,12 -> %0d", u, resp_rd[u]);
    endtask

    task automatic test_both(input int u);
        int k, who, w, first;
        logic [31:0] exp_val;
        test_reset(u);
        @(negedge clk);
        set_req(u, 0, ALU_OP_SUB, 32'd18, 32'd12);
        set_req(u, 1, ALU_OP_XOR, 32'd24, 32'd20);
        first = exp_rr[u];
        for (int n = 0; n < 2; n++) begin
            w = (n == 0) ? exp_rr[u] : 1 - first;
            #1;
            checks++;
            if ({req0_ready[u], req1_ready[u]} !== ((w == 0) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL both_grant%0d u%0d: got %b required winner %0d", n, u, {req0_ready[u], req1_ready[u]}, w); end
            @(posedge clk); #1;
            if (w == 0) req0_valid[u] = 1'b0; else req1_valid[u] = 1'b0;
            wait_resp(u, k, who);
            exp_val = (w == 0) ? 32'd6 : 32'd12;
            checks++;
            if (k !== lat_of(u) + 1 || who !== w || resp_rd[u] !== exp_val)
                begin errors++; $display("FAIL both_resp%0d u%0d: k=%0d who=%0d rd=%h required k=%0d who=%0d rd=%h",
                                         n, u, k, who, resp_rd[u], lat_of(u) + 1, w, exp_val); end
            $display("txn u%0d both req%0d -> %0d", u, who, resp_rd[u]);
            @(negedge clk);
            exp_rr[u] = 1 - w;
        end
        checks++;
        if (first !== 0)
            begin errors++; $display("FAIL both_order u%0d: first served %0d required 0", u, first); end
        // Pointer should be back on req0: a fresh tie must go to req0
        #1;
        req0_valid[u] = 1'b1; req1_valid[u] = 1'b1;
        #1;
        checks++;
        if ({req0_ready[u], req1_ready[u]} !== 2'b10)
            begin errors++; $display("FAIL both_rr_back u%0d: got %b required 10", u, {req0_ready[u], req1_ready[u]}); end
        req0_valid[u] = 1'b0; req1_valid[u] = 1'b0;
    endtask

    task automatic test_backpressure(input int u);
        int k, who;
        @(negedge clk);
        resp0_ready[u] = 1'b1; resp1_ready[u] = 1'b0;
        set_req(u, 1, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1);
        #1;
        checks++;
        if ({req0_ready[u], req1_ready[u]} !== 2'b01)
            begin errors++; $display("FAIL bp_ready u%0d: got %b required 01", u, {req0_ready[u], req1_ready[u]}); end
        @(posedge clk); #1;
        req1_valid[u] = 1'b0;
        set_req(u, 0, ALU_OP_ADD, 32'd5, 32'd7);
        wait_resp(u, k, who);
        checks++;
        if (k !== lat_of(u) + 1 || who !== 1 || resp_rd[u] !== 32'd1 || req0_ready[u] !== 1'b0)
            begin errors++; $display("FAIL bp_resp u%0d: k=%0d who=%0d rd=%h rdy0=%b required k=%0d who=1 rd=1 rdy0=0",
                                     u, k, who, resp_rd[u], req0_ready[u], lat_of(u) + 1); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({resp1_valid[u], resp_rd[u], req0_ready[u]} !== {1'b1, 32'd1, 1'b0})
                begin errors++; $display("FAIL bp_hold%0d u%0d: valid=%b rd=%h rdy0=%b required 1/1/0",
                                         i, u, resp1_valid[u], resp_rd[u], req0_ready[u]); end
        end
        resp1_ready[u] = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({resp1_valid[u], busy[u], req0_ready[u]} !== 3'b001)
            begin errors++; $display("FAIL bp_release u%0d: valid/busy/rdy0 got %b required 001",
                                     u, {resp1_valid[u], busy[u], req0_ready[u]}); end
        exp_rr[u] = 0;
        @(posedge clk); #1;
        req0_valid[u] = 1'b0;
        wait_resp(u, k, who);
        checks++;
        if (k !== lat_of(u) + 1 || who !== 0 || resp_rd[u] !== 32'd12)
            begin errors++; $display("FAIL bp_followup u%0d: k=%0d who=%0d rd=%h required who=0 rd=c", u, k, who, resp_rd[u]); end
        @(negedge clk);
        exp_rr[u] = 1;
        $display("txn u%0d backpressure SLT then ADD -> %0d", u, resp_rd[u]);
    endtask

    task automatic test_alternate(input int u);
        int cyc, last, nacc, nresp, exp_w, w, who, expo;
        int owners [$];
        logic [31:0] exp_val;
        test_reset(u);
        @(negedge clk);
        set_req(u, 0, ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        set_req(u, 1, ALU_OP_SRA,  32'hFFFF_FFFE, 32'd1);
        cyc = 0; last = 0; nacc = 0; nresp = 0; exp_w = exp_rr[u];
        while (nresp < 6 && cyc < 200) begin
            #1;
            if (req0_ready[u] || req1_ready[u]) begin
                w = req0_ready[u] ? 0 : 1;
                checks++;
                if ((req0_ready[u] && req1_ready[u]) || w !== exp_w)
                    begin errors++; $display("FAIL alt_grant%0d u%0d: got %b required winner %0d", nacc, u, {req0_ready[u], req1_ready[u]}, exp_w); end
                if (nacc > 0) begin
                    checks++;
                    if (cyc - last !== lat_of(u) + 2)
                        begin errors++; $display("FAIL alt_spacing%0d u%0d: got %0d required %0d", nacc, u, cyc - last, lat_of(u) + 2); end
                end
                last = cyc;
                owners.push_back(w);
                nacc++;
                exp_w = 1 - w;
                if (nacc == 6) begin
                    @(posedge clk); #1;
                    req0_valid[u] = 1'b0; req1_valid[u] = 1'b0;
                end
            end
            if (resp0_valid[u] || resp1_valid[u]) begin
                who = resp0_valid[u] ? 0 : 1;
                expo = (owners.size() > 0) ? owners.pop_front() : -1;
                exp_val = (expo == 0) ? 32'd0 : 32'hFFFF_FFFF;
                checks++;
                if (who !== expo || who !== (nresp % 2) || resp_rd[u] !== exp_val)
                    begin errors++; $display("FAIL alt_resp%0d u%0d: who=%0d rd=%h required who=%0d rd=%h", nresp, u, who, resp_rd[u], nresp % 2, exp_val); end
                $display("txn u%0d alternate req%0d -> %h", u, who, resp_rd[u]);
                nresp++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (nresp !== 6 || nacc !== 6)
            begin errors++; $display("FAIL alt_count u%0d: got %0d accepts %0d responses required 6/6", u, nacc, nresp); end
        exp_rr[u] = exp_w;
    endtask

    task automatic test_reset_midop(input int u);
        int k, who;
        bit seen;
        @(negedge clk);
        set_req(u, 0, ALU_OP_OR, 32'd24, 32'd20);
        #1;
        checks++;
        if (req0_ready[u] !== 1'b1)
            begin errors++; $display("FAIL midrst_accept u%0d: got %b required 1", u, req0_ready[u]); end
        @(posedge clk); #1;
        req0_valid[u] = 1'b0;
        #2;
        rst[u] = 1'b0;
        #1;
        checks++;
        if ({busy[u], resp0_valid[u], resp1_valid[u], alu_mode[u], alu_rs1[u], alu_rs2[u], resp_rd[u]} !== '0)
            begin errors++; $display("FAIL midrst_async u%0d: busy=%b alu=%h/%h/%h rd=%h required all 0",
                                     u, busy[u], alu_mode[u], alu_rs1[u], alu_rs2[u], resp_rd[u]); end
        repeat (2) @(negedge clk);
        rst[u] = 1'b1;
        exp_rr[u] = 0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk); #1;
            if (resp0_valid[u] || resp1_valid[u] || busy[u]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0)
            begin errors++; $display("FAIL midrst_dropped u%0d: stray activity got %b required 0", u, seen); end
        @(negedge clk);
        set_req(u, 0, ALU_OP_AND, 32'd24, 32'd20);
        @(posedge clk); #1;
        req0_valid[u] = 1'b0;
        wait_resp(u, k, who);
        checks++;
        if (k !== lat_of(u) + 1 || who !== 0 || resp_rd[u] !== 32'd16)
            begin errors++; $display("FAIL midrst_reissue u%0d: k=%0d who=%0d rd=%h required who=0 rd=10", u, k, who, resp_rd[u]); end
        @(negedge clk);
        exp_rr[u] = 1;
        $display("txn u%0d reissue AND 24,20 -> %0d", u, resp_rd[u]);
    endtask

    task automatic test_lat3(input int u);
        int cnt, rk, ak, k, who;
        @(negedge clk);
        set_req(u, 0, ALU_OP_SLL, 32'd2, 32'd1);
        #1;
        checks++;
        if (req0_ready[u] !== 1'b1)
            begin errors++; $display("FAIL lat3_accept u%0d: got %b required 1", u, req0_ready[u]); end
        @(posedge clk); #1;
        set_req(u, 0, ALU_OP_SRL, 32'd2, 32'd1);
        cnt = 0; rk = -1; ak = -1;
        while (ak < 0 && cnt < 30) begin
            @(negedge clk); #1;
            cnt++;
            if (cnt <= lat_of(u) + 1) begin
                checks++;
                if ({alu_mode[u], alu_rs1[u], alu_rs2[u]} !== {ALU_OP_SLL, 32'd2, 32'd1})
                    begin errors++; $display("FAIL lat3_alu_hold%0d u%0d: got %h/%h/%h", cnt, u, alu_mode[u], alu_rs1[u], alu_rs2[u]); end
            end
            if (resp0_valid[u] && rk < 0) begin
                rk = cnt;
                checks++;
                if (resp_rd[u] !== 32'd4)
                    begin errors++; $display("FAIL lat3_sll u%0d: got %h required 4", u, resp_rd[u]); end
            end
            if (req0_ready[u]) ak = cnt;
        end
        checks++;
        if (rk !== lat_of(u) + 1)
            begin errors++; $display("FAIL lat3_resp_edge u%0d: got %0d required %0d", u, rk, lat_of(u) + 1); end
        checks++;
        if (ak !== lat_of(u) + 2)
            begin errors++; $display("FAIL lat3_next_accept u%0d: got %0d required %0d", u, ak, lat_of(u) + 2); end
        @(posedge clk); #1;
        req0_valid[u] = 1'b0;
        wait_resp(u, k, who);
        checks++;
        if (k !== lat_of(u) + 1 || who !== 0 || resp_rd[u] !== 32'd1)
            begin errors++; $display("FAIL lat3_srl u%0d: k=%0d who=%0d rd=%h required who=0 rd=1", u, k, who, resp_rd[u]); end
        @(negedge clk);
        exp_rr[u] = 1;
        $display("txn u%0d lat3 SLL/SRL done rd=%0d", u, resp_rd[u]);
    endtask

    task automatic test_random(input int u, input int n);
        int v, w, bp, k, who;
        logic [3:0]  m0, m1, mw;
        logic [31:0] a0, b0, a1, b1, exp_val;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            v  = $urandom_range(1, 3);
            m0 = 4'($urandom_range(0, 15)); a0 = $urandom; b0 = $urandom;
            m1 = 4'($urandom_range(0, 15)); a1 = $urandom; b1 = $urandom;
            bp = $urandom_range(0, 3);
            resp0_ready[u] = (bp == 0); resp1_ready[u] = (bp == 0);
            if (v[0]) set_req(u, 0, m0, a0, b0);
            if (v[1]) set_req(u, 1, m1, a1, b1);
            w = (v == 3) ? exp_rr[u] : ((v == 1) ? 0 : 1);
            mw = (w == 0) ? m0 : m1;
            exp_val = (w == 0) ? alu_func(m0, a0, b0) : alu_func(m1, a1, b1);
            #1;
            checks++;
            if ({req0_ready[u], req1_ready[u]} !== ((w == 0) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL rnd_grant%0d u%0d: got %b required winner %0d", i, u, {req0_ready[u], req1_ready[u]}, w); end
            @(posedge clk); #1;
            req0_valid[u] = 1'b0; req1_valid[u] = 1'b0;
            wait_resp(u, k, who);
            checks++;
            if (k !== lat_of(u) + 1 || who !== w || resp_rd[u] !== exp_val || (resp0_valid[u] && resp1_valid[u]))
                begin errors++; $display("FAIL rnd_resp%0d u%0d: k=%0d who=%0d rd=%h required k=%0d who=%0d rd=%h",
                                         i, u, k, who, resp_rd[u], lat_of(u) + 1, w, exp_val); end
            for (int j = 0; j < bp; j++) begin
                @(negedge clk); #1;
                checks++;
                if (resp_rd[u] !== exp_val || busy[u] !== 1'b1)
                    begin errors++; $display("FAIL rnd_hold%0d u%0d: rd=%h busy=%b required rd=%h busy=1", i, u, resp_rd[u], busy[u], exp_val); end
            end
            resp0_ready[u] = 1'b1; resp1_ready[u] = 1'b1;
            @(negedge clk); #1;
            checks++;
            if (busy[u] !== 1'b0)
                begin errors++; $display("FAIL rnd_idle%0d u%0d: busy got %b required 0", i, u, busy[u]); end
            exp_rr[u] = 1 - w;
            $display("txn u%0d rnd%0d req%0d mode=%h bp=%0d rd=%h", u, i, w, mw, bp, resp_rd[u]);
        end
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0;
            clear_inputs(u);
            exp_rr[u] = 0;
        end
        for (int u = 0; u < 2; u++) begin
            test_reset(u);
            test_single(u);
            test_both(u);
            test_backpressure(u);
            test_alternate(u);
            test_reset_midop(u);
            test_random(u, 40);
        end
        test_lat3(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
